// File: rtl/button_press_decoder.sv
// Push-button conditioner feeding the LED sequencer.
// Synchronises the raw pin, debounces it, and produces one-cycle press,
// release and long-press strobes, a debounced level, and a run enable that
// toggles on every completed short press.
//
// Ports:
//   clk              system clock
//   rst              asynchronous reset, active-low
//   button_in        raw asynchronous button pin
//   press_pulse      one-cycle strobe when a press is accepted
//   release_pulse    one-cycle strobe when a release is accepted
//   long_press_pulse one-cycle strobe when a hold reaches LONG_PRESS_CYCLES
//   level            debounced button state (1 = pressed)
//   run_en           toggled by each completed short press
module button_press_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1_000_000,
    parameter int unsigned LONG_PRESS_CYCLES = 100_000_000,
    parameter bit          ACTIVE_HIGH       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic button_in,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse,
    output logic level,
    output logic run_en
);

    localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_PRESS_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    // Pin level that means "not pressed"; also the synchroniser reset value.
    localparam logic INVERT = (ACTIVE_HIGH == 1'b0);

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        PRESSED     = 3'd2,
        LONG_HELD   = 3'd3,
        DEB_RELEASE = 3'd4
    } state_t;

    state_t              state;
    logic                sync1;
    logic                sync2;
    logic                long_flag;
    logic [DEB_W-1:0]    deb_cnt;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                b_act;

    // Normalised button: 1 means pressed regardless of pin polarity.
    assign b_act = sync2 ^ INVERT;

    // Synchroniser, debounce/hold counters and press-tracking FSM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1            <= INVERT;
            sync2            <= INVERT;
            state            <= IDLE;
            deb_cnt          <= '0;
            hold_cnt         <= '0;
            long_flag        <= 1'b0;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;
            level            <= 1'b0;
            run_en           <= 1'b0;
        end else begin
            sync1            <= button_in;
            sync2            <= sync1;
            press_pulse      <= 1'b0;
            release_pulse    <= 1'b0;
            long_press_pulse <= 1'b0;

            case (state)
                IDLE: begin
                    if (b_act) begin
                        state   <= DEB_PRESS;
                        deb_cnt <= '0;
                    end
                end

                DEB_PRESS: begin
                    if (!b_act) begin
                        state <= IDLE;
                    end else if (deb_cnt == DEB_LAST) begin
                        state       <= PRESSED;
                        press_pulse <= 1'b1;
                        level       <= 1'b1;
                        hold_cnt    <= '0;
                        long_flag   <= 1'b0;
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end

                PRESSED: begin
                    if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                    // A release seen on the terminal cycle suppresses the long pulse.
                    if (!b_act) begin
                        state   <= DEB_RELEASE;
                        deb_cnt <= '0;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state            <= LONG_HELD;
                        long_press_pulse <= 1'b1;
                        long_flag        <= 1'b1;
                    end
                end

                LONG_HELD: begin
                    if (!b_act) begin
                        state   <= DEB_RELEASE;
                        deb_cnt <= '0;
                    end
                end

                DEB_RELEASE: begin
                    // hold_cnt is frozen here so a glitch only delays the long pulse.
                    if (b_act) begin
                        state <= long_flag ? LONG_HELD : PRESSED;
                    end else if (deb_cnt == DEB_LAST) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        level         <= 1'b0;
                        if (!long_flag) begin
                            run_en <= ~run_en;
                        end
                    end else begin
                        deb_cnt <= deb_cnt + DEB_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed bench for button_press_decoder (DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=20). An active-high and an active-low instance are driven
// with complementary pins and must both match the same expected outputs.
module tb_button_press_decoder;

    logic clk;
    logic rst;
    logic button;
    logic button_n;

    logic press_h, release_h, long_h, level_h, run_h;
    logic press_l, release_l, long_l, level_l, run_l;

    int vectors;
    int miscompares;

    assign button_n = ~button;

    button_press_decoder #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .ACTIVE_HIGH      (1'b1)
    ) dut_h (
        .clk             (clk),
        .rst             (rst),
        .button_in       (button),
        .press_pulse     (press_h),
        .release_pulse   (release_h),
        .long_press_pulse(long_h),
        .level           (level_h),
        .run_en          (run_h)
    );

    button_press_decoder #(
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(20),
        .ACTIVE_HIGH      (1'b0)
    ) dut_l (
        .clk             (clk),
        .rst             (rst),
        .button_in       (button_n),
        .press_pulse     (press_l),
        .release_pulse   (release_l),
        .long_press_pulse(long_l),
        .level           (level_l),
        .run_en          (run_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // exp = {press, release, long, level, run_en}
    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] oh;
        logic [4:0] ol;
        oh = {press_h, release_h, long_h, level_h, run_h};
        ol = {press_l, release_l, long_l, level_l, run_l};
        vectors++;
        assert (oh === exp) else begin
            miscompares++;
            $error("FAIL %s (active-high) got %b expected %b", tag, oh, exp);
        end
        vectors++;
        assert (ol === exp) else begin
            miscompares++;
            $error("FAIL %s (active-low) got %b expected %b", tag, ol, exp);
        end
    endtask

    // n quiet cycles: no strobes, given level and run_en.
    task automatic quiet(input string tag, input int n, input logic lv, input logic re);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk(tag, {3'b000, lv, re});
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        button      = 1'b0;

        // Reset held for 3 cycles, then idle with button released.
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("reset", 5'b00000);
        end
        rst = 1'b1;
        quiet("idle_after_reset", 50, 1'b0, 1'b0);

        // Clean short press of 10 cycles: press at +7, release 7 after drop.
        button = 1'b1;
        quiet("short_deb", 6, 1'b0, 1'b0);
        cyc(); chk("short_press", 5'b10010);
        quiet("short_hold", 3, 1'b1, 1'b0);
        button = 1'b0;
        quiet("short_deb_rel", 6, 1'b1, 1'b0);
        cyc(); chk("short_release", 5'b01001);
        quiet("short_after", 10, 1'b0, 1'b1);

        // Bounce: 2-cycle high/low segments never satisfy the debounce window.
        button = 1'b1; quiet("bounce", 2, 1'b0, 1'b1);
        button = 1'b0; quiet("bounce", 2, 1'b0, 1'b1);
        button = 1'b1; quiet("bounce", 2, 1'b0, 1'b1);
        button = 1'b0; quiet("bounce_settle", 10, 1'b0, 1'b1);

        // Clean 30-cycle press: one press, long at press+20, release keeps run_en.
        button = 1'b1;
        quiet("p30_deb", 6, 1'b0, 1'b1);
        cyc(); chk("p30_press", 5'b10011);
        quiet("p30_hold", 19, 1'b1, 1'b1);
        cyc(); chk("p30_long", 5'b00111);
        quiet("p30_long_held", 3, 1'b1, 1'b1);
        button = 1'b0;
        quiet("p30_deb_rel", 6, 1'b1, 1'b1);
        cyc(); chk("p30_release", 5'b01001);
        quiet("p30_after", 5, 1'b0, 1'b1);

        // Long press of 40 cycles.
        button = 1'b1;
        quiet("long_deb", 6, 1'b0, 1'b1);
        cyc(); chk("long_press", 5'b10011);
        quiet("long_hold", 19, 1'b1, 1'b1);
        cyc(); chk("long_pulse", 5'b00111);
        quiet("long_held", 13, 1'b1, 1'b1);
        button = 1'b0;
        quiet("long_deb_rel", 6, 1'b1, 1'b1);
        cyc(); chk("long_release", 5'b01001);
        quiet("long_after", 5, 1'b0, 1'b1);

        // Release glitch of 2 cycles mid-hold delays the long pulse by 2.
        button = 1'b1;
        quiet("glitch_deb", 6, 1'b0, 1'b1);
        cyc(); chk("glitch_press", 5'b10011);
        quiet("glitch_pre", 3, 1'b1, 1'b1);
        button = 1'b0;
        quiet("glitch_low", 2, 1'b1, 1'b1);
        button = 1'b1;
        quiet("glitch_resume", 16, 1'b1, 1'b1);
        cyc(); chk("glitch_long", 5'b00111);
        quiet("glitch_tail", 1, 1'b1, 1'b1);
        button = 1'b0;
        quiet("glitch_deb_rel", 6, 1'b1, 1'b1);
        cyc(); chk("glitch_release", 5'b01001);
        quiet("glitch_after", 5, 1'b0, 1'b1);

        // Reset while PRESSED; button still held afterwards gives a fresh press.
        button = 1'b1;
        quiet("mid_deb", 6, 1'b0, 1'b1);
        cyc(); chk("mid_press", 5'b10011);
        quiet("mid_hold", 3, 1'b1, 1'b1);
        rst = 1'b0;
        #1; chk("mid_reset_async", 5'b00000);
        quiet("mid_reset_hold", 2, 1'b0, 1'b0);
        rst = 1'b1;
        quiet("mid_re_deb", 6, 1'b0, 1'b0);
        cyc(); chk("mid_re_press", 5'b10010);
        quiet("mid_re_hold", 2, 1'b1, 1'b0);
        button = 1'b0;
        quiet("mid_deb_rel", 6, 1'b1, 1'b0);
        cyc(); chk("mid_release", 5'b01001);

        // Second short press toggles run_en back to 0.
        button = 1'b1;
        quiet("tog_deb", 6, 1'b0, 1'b1);
        cyc(); chk("tog_press", 5'b10011);
        quiet("tog_hold", 2, 1'b1, 1'b1);
        button = 1'b0;
        quiet("tog_deb_rel", 6, 1'b1, 1'b1);
        cyc(); chk("tog_release", 5'b01000);
        quiet("tog_after", 5, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
